// File: rtl/btn_in_port.sv
// btn_in_port: synchronize, debounce and edge-latch WIDTH button lines behind a read-to-clear CPU port.
// Optional macro BTN_IN_IRQ_EN adds a registered edge-pending interrupt on irq (tied low otherwise).
module btn_in_port #(
    parameter int WIDTH     = 12,
    parameter int DB_CYCLES = 50000,
    parameter int RD_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_raw,
    input  logic             rd_en,
    input  logic             rd_addr,
    output logic [RD_W-1:0]  rd_data,
    output logic             rd_valid,
    output logic             irq
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1, r_sync2, r_stable, r_pending;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] w_flip, w_rise, w_clr;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end

    // A bit flips only after DB_CYCLES consecutive disagreeing cycles; any agreement restarts the count.
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        assign w_flip[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
        always_ff @(posedge clk or posedge rst)
            if (rst)
                r_cnt[i] <= '0;
            else
                r_cnt[i] <= (r_sync2[i] == r_stable[i] || w_flip[i]) ? '0 : r_cnt[i] + 1'b1;
    end

    assign w_rise = w_flip & r_sync2;
    assign w_clr  = (rd_en && rd_addr) ? r_pending : '0;

    // Clear only the returned snapshot; a rise on the same edge survives.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_stable  <= '0;
            r_pending <= '0;
        end else begin
            r_stable  <= r_stable ^ w_flip;
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_addr ? RD_W'(r_pending) : RD_W'(r_stable);
        end

`ifdef BTN_IN_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_irq <= 1'b0;
        else
            r_irq <= |r_pending;
    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_btn_in_port.sv
// tb_btn_in_port: directed checks of reset, debounce latency, glitch rejection, read-to-clear and set-wins race.
module tb_btn_in_port;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] btn_raw = 12'hFFF;
    logic        rd_en = 1'b0;
    logic        rd_addr = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        irq;
    int          checks = 0;
    int          errors = 0;

`ifdef BTN_IN_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    btn_in_port #(.WIDTH(12), .DB_CYCLES(4), .RD_W(16)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic addr, input logic [15:0] exp, input string tag);
        rd_en = 1'b1;
        rd_addr = addr;
        step();
        rd_en = 1'b0;
        chk(tag, rd_data, exp);
        chk({tag, "_valid"}, {15'd0, rd_valid}, 16'h0001);
    endtask

    initial begin
        rd_en = 1'b1;
        rd_addr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_data", rd_data, 16'h0000);
            chk("rst_valid", {15'd0, rd_valid}, 16'h0000);
            chk("rst_irq", {15'd0, irq}, 16'h0000);
        end
        rd_en = 1'b0;
        rst = 1'b0;
        wait_n(10);
        chk("post_rst_irq", {15'd0, irq}, {15'd0, IRQ_ON});
        rd(1'b0, 16'h0FFF, "post_rst_stable");
        rd(1'b1, 16'h0FFF, "post_rst_flags");
        chk("post_rst_irq_hold", {15'd0, irq}, {15'd0, IRQ_ON});
        step();
        chk("post_rst_irq_clr", {15'd0, irq}, 16'h0000);
        rd(1'b1, 16'h0000, "post_rst_flags_empty");

        btn_raw = 12'h000;
        wait_n(10);
        rd(1'b0, 16'h0000, "fall_stable");
        rd(1'b1, 16'h0000, "fall_no_flag");

        // Continuous stable reads show the exact edge the press lands.
        btn_raw = 12'h001;
        rd_en = 1'b1;
        rd_addr = 1'b0;
        wait_n(6);
        chk("press_early", rd_data, 16'h0000);
        chk("press_irq_early", {15'd0, irq}, 16'h0000);
        step();
        chk("press_stable", rd_data, 16'h0001);
        chk("press_irq", {15'd0, irq}, {15'd0, IRQ_ON});
        rd_en = 1'b0;
        rd(1'b1, 16'h0001, "press_flag");
        step();
        chk("press_irq_clr", {15'd0, irq}, 16'h0000);

        btn_raw = 12'h009;
        wait_n(3);
        btn_raw = 12'h001;
        wait_n(10);
        rd(1'b0, 16'h0001, "glitch_stable");
        rd(1'b1, 16'h0000, "glitch_flag");

        btn_raw = 12'h009;
        wait_n(4);
        btn_raw = 12'h001;
        wait_n(2);
        rd(1'b0, 16'h0009, "pulse_stable");
        wait_n(10);
        rd(1'b0, 16'h0001, "pulse_back");
        rd(1'b1, 16'h0008, "pulse_flag");

        btn_raw = 12'h000;
        wait_n(10);
        btn_raw = 12'h005;
        wait_n(10);
        chk("rc_irq", {15'd0, irq}, {15'd0, IRQ_ON});
        rd(1'b1, 16'h0005, "rc_flags");
        step();
        chk("rc_valid_drop", {15'd0, rd_valid}, 16'h0000);
        chk("rc_data_hold", rd_data, 16'h0005);
        chk("rc_irq_clr", {15'd0, irq}, 16'h0000);
        rd(1'b1, 16'h0000, "rc_empty");

        btn_raw = 12'h000;
        wait_n(10);
        btn_raw = 12'h001;
        wait_n(10);
        btn_raw = 12'h005;
        wait_n(5);
        rd(1'b1, 16'h0001, "race_snapshot");
        rd(1'b1, 16'h0004, "race_set_wins");

        btn_raw = 12'h000;
        wait_n(10);
        btn_raw = 12'h010;
        wait_n(4);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", rd_data, 16'h0000);
        chk("mid_rst_valid", {15'd0, rd_valid}, 16'h0000);
        chk("mid_rst_irq", {15'd0, irq}, 16'h0000);
        wait_n(2);
        rst = 1'b0;
        rd_en = 1'b1;
        rd_addr = 1'b0;
        wait_n(6);
        chk("mid_rst_early", rd_data, 16'h0000);
        step();
        chk("mid_rst_stable", rd_data, 16'h0010);
        rd_en = 1'b0;
        rd(1'b1, 16'h0010, "mid_rst_flag");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
